// File: rtl/prores_vlc_encoder.sv
// ProRes-style VLC encoder: Rice / exp-Golomb codeword generation with
// optional sign bit, three-stage stallable pipeline and a running bit counter.
module prores_vlc_encoder #(
  parameter int VAL_W  = 16,
  parameter int CODE_W = 32,
  parameter int LEN_W  = $clog2(CODE_W + 2)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VAL_W-1:0]  in_val,
  input  logic [2:0]        in_rice_k,
  input  logic [2:0]        in_exp_k,
  input  logic [1:0]        in_switch,
  input  logic              in_sign_en,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [LEN_W-1:0]  out_len,
  output logic              out_ovf,
  input  logic              stat_clr,
  output logic [31:0]       stat_bits
);

  localparam int AW = VAL_W + 8;
  localparam int CW = (CODE_W > AW + 1) ? CODE_W : AW + 1;

  function automatic logic [AW-1:0] msb_idx(input logic [AW-1:0] x);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = 0; i < AW; i++) begin
      if (x[i]) idx = AW'(i);
    end
    return idx;
  endfunction

  logic w_en;
  assign w_en     = !out_valid | out_ready;
  assign in_ready = w_en;

  // ---- stage 0 -> 1: threshold and mode decision
  logic [AW-1:0] w_val_p0, w_t_p0;
  logic          w_exp_p0;
  assign w_val_p0 = AW'(in_val);
  assign w_t_p0   = (AW'(in_switch) + AW'(1)) << in_rice_k;
  assign w_exp_p0 = (w_val_p0 >= w_t_p0);

  logic          r_vld_p1, r_exp_p1, r_sapp_p1, r_sgn_p1;
  logic [AW-1:0] r_val_p1, r_t_p1;
  logic [2:0]    r_rk_p1, r_ek_p1;
  logic [1:0]    r_sw_p1;

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_val_p1  <= w_val_p0;
      r_t_p1    <= w_t_p0;
      r_exp_p1  <= w_exp_p0;
      r_rk_p1   <= in_rice_k;
      r_ek_p1   <= in_exp_k;
      r_sw_p1   <= in_switch;
      r_sapp_p1 <= in_sign_en & (in_val != '0);
      r_sgn_p1  <= in_sign;
    end
  end

  // ---- stage 1 -> 2: prefix count (q or n) and the value bits after it
  logic [AW-1:0] w_v_p1, w_q_p1, w_mask_p1, w_bits_p1, w_cnt_p1;
  assign w_v_p1    = r_val_p1 - r_t_p1 + (AW'(1) << r_ek_p1);
  assign w_q_p1    = r_val_p1 >> r_rk_p1;
  assign w_mask_p1 = (AW'(1) << r_rk_p1) - AW'(1);
  assign w_bits_p1 = r_exp_p1 ? w_v_p1
                              : ((AW'(1) << r_rk_p1) | (r_val_p1 & w_mask_p1));
  assign w_cnt_p1  = r_exp_p1 ? msb_idx(w_v_p1) : w_q_p1;

  logic          r_vld_p2, r_exp_p2, r_sapp_p2, r_sgn_p2;
  logic [AW-1:0] r_bits_p2, r_cnt_p2;
  logic [2:0]    r_rk_p2, r_ek_p2;
  logic [1:0]    r_sw_p2;

  always_ff @(posedge clk) begin
    if (w_en) begin
      r_bits_p2 <= w_bits_p1;
      r_cnt_p2  <= w_cnt_p1;
      r_exp_p2  <= r_exp_p1;
      r_rk_p2   <= r_rk_p1;
      r_ek_p2   <= r_ek_p1;
      r_sw_p2   <= r_sw_p1;
      r_sapp_p2 <= r_sapp_p1;
      r_sgn_p2  <= r_sgn_p1;
    end
  end

  // ---- stage 2 -> 3: length, sign append, overflow; leading zeros are implicit
  logic [AW-1:0] w_len_p2;
  logic [CW-1:0] w_code_p2;
  logic          w_ovf_p2;
  assign w_len_p2  = (r_exp_p2 ? ((r_cnt_p2 << 1) - AW'(r_ek_p2) + AW'(r_sw_p2) + AW'(2))
                               : (r_cnt_p2 + AW'(1) + AW'(r_rk_p2)))
                     + AW'(r_sapp_p2);
  assign w_code_p2 = r_sapp_p2 ? ((CW'(r_bits_p2) << 1) | CW'(r_sgn_p2)) : CW'(r_bits_p2);
  assign w_ovf_p2  = (w_len_p2 > AW'(CODE_W));

  logic w_hs;
  assign w_hs = out_valid & out_ready & !out_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_len   <= '0;
      out_ovf   <= 1'b0;
      stat_bits <= '0;
    end else begin
      if (w_en) begin
        r_vld_p1  <= in_valid;
        r_vld_p2  <= r_vld_p1;
        out_valid <= r_vld_p2;
        if (r_vld_p2) begin
          out_ovf  <= w_ovf_p2;
          out_code <= w_ovf_p2 ? '0 : w_code_p2[CODE_W-1:0];
          out_len  <= w_ovf_p2 ? '0 : w_len_p2[LEN_W-1:0];
        end
      end
      // A clear coinciding with a handshake restarts the total at that codeword.
      if (stat_clr) begin
        stat_bits <= w_hs ? 32'(out_len) : 32'd0;
      end else if (w_hs) begin
        stat_bits <= stat_bits + 32'(out_len);
      end
    end
  end

endmodule

// File: tb/tb_prores_vlc_encoder.sv
// Self-checking bench for prores_vlc_encoder: directed spec vectors, random
// stream with stalls against a bit-list reference model, stat clear and reset.
module tb_prores_vlc_encoder;
  localparam int VAL_W  = 16;
  localparam int CODE_W = 32;
  localparam int LEN_W  = $clog2(CODE_W + 2);

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [VAL_W-1:0]  in_val = '0;
  logic [2:0]        in_rice_k = '0;
  logic [2:0]        in_exp_k = '0;
  logic [1:0]        in_switch = '0;
  logic              in_sign_en = 1'b0;
  logic              in_sign = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CODE_W-1:0] out_code;
  logic [LEN_W-1:0]  out_len;
  logic              out_ovf;
  logic              stat_clr = 1'b0;
  logic [31:0]       stat_bits;

  always #5 clk = ~clk;

  prores_vlc_encoder #(.VAL_W(VAL_W), .CODE_W(CODE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .in_rice_k(in_rice_k), .in_exp_k(in_exp_k), .in_switch(in_switch),
    .in_sign_en(in_sign_en), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_len(out_len), .out_ovf(out_ovf),
    .stat_clr(stat_clr), .stat_bits(stat_bits)
  );

  typedef struct {
    logic [31:0] code;
    int          len;
    bit          ovf;
    int          acyc;
  } exp_t;

  exp_t        expq[$];
  int          ncmp = 0;
  int          nerr = 0;
  int          cyc_n = 0;
  logic [31:0] mstat = '0;
  bit          prev_stall = 0;
  logic [CODE_W-1:0] s_code;
  logic [LEN_W-1:0]  s_len;
  logic              s_ovf;
  bit          chk_lat = 0;
  bit          dir_en = 0;
  logic [31:0] dir_code;
  int          dir_len;
  bit          dir_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: build the codeword as an explicit MSB-first bit list.
  function automatic void ref_enc(input int val, input int rk, input int ek, input int sw,
                                  input int sen, input int sg,
                                  output logic [31:0] code, output int len, output bit ovf);
    bit bq[$];
    int t, q, v, n;
    t = (sw + 1) << rk;
    if (val < t) begin
      q = val >> rk;
      repeat (q) bq.push_back(1'b0);
      bq.push_back(1'b1);
      for (int i = rk - 1; i >= 0; i--) bq.push_back(((val >> i) & 1) != 0);
    end else begin
      v = val - t + (1 << ek);
      n = 0;
      while ((v >> (n + 1)) != 0) n++;
      repeat (n - ek + sw + 1) bq.push_back(1'b0);
      for (int i = n; i >= 0; i--) bq.push_back(((v >> i) & 1) != 0);
    end
    if (sen != 0 && val != 0) bq.push_back(sg != 0);
    code = '0;
    if (bq.size() > CODE_W) begin
      ovf = 1;
      len = 0;
    end else begin
      ovf = 0;
      len = bq.size();
      foreach (bq[i]) code = {code[30:0], bq[i]};
    end
  endfunction

  task automatic cycle(input bit v, input int val, input int rk, input int ek, input int sw,
                       input int sen, input int sg, input bit ordy, input bit clr);
    exp_t e;
    in_valid   = v;
    in_val     = VAL_W'(val);
    in_rice_k  = 3'(rk);
    in_exp_k   = 3'(ek);
    in_switch  = 2'(sw);
    in_sign_en = sen[0];
    in_sign    = sg[0];
    out_ready  = ordy;
    stat_clr   = clr;
    #3;
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_code", 64'(out_code), 64'(s_code));
      chk("hold_len", 64'(out_len), 64'(s_len));
      chk("hold_ovf", 64'(out_ovf), 64'(s_ovf));
    end
    if (in_valid && in_ready) begin
      if (dir_en) begin
        e.code = dir_code; e.len = dir_len; e.ovf = dir_ovf;
      end else begin
        ref_enc(val, rk, ek, sw, sen, sg, e.code, e.len, e.ovf);
      end
      e.acyc = cyc_n;
      expq.push_back(e);
    end
    if (out_valid && out_ready) begin
      chk("output_expected", 64'(expq.size() > 0), 64'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_code", 64'(out_code), 64'(e.code));
        chk("out_len", 64'(out_len), 64'(e.len));
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
        if (chk_lat) chk("latency", 64'(cyc_n - e.acyc), 64'd3);
        if (clr) mstat = e.ovf ? 32'd0 : 32'(e.len);
        else if (!e.ovf) mstat = mstat + 32'(e.len);
      end
    end else if (clr) begin
      mstat = '0;
    end
    prev_stall = out_valid && !out_ready;
    s_code = out_code; s_len = out_len; s_ovf = out_ovf;
    @(posedge clk); #1;
    cyc_n++;
    chk("stat_bits", 64'(stat_bits), 64'(mstat));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic dsend(input int val, input int rk, input int ek, input int sw, input int sen,
                       input int sg, input logic [31:0] code, input int len, input bit ovf);
    dir_en = 1; dir_code = code; dir_len = len; dir_ovf = ovf;
    cycle(1, val, rk, ek, sw, sen, sg, 1, 0);
    dir_en = 0;
    idle(4);
    chk("directed_drained", 64'(expq.size()), 64'd0);
  endtask

  function automatic int rval();
    int r;
    r = $urandom_range(0, 16);
    return int'($urandom_range(0, (1 << r) - 1));
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_code", 64'(out_code), 64'd0);
    chk("rst_out_len", 64'(out_len), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_stat_bits", 64'(stat_bits), 64'd0);
    reset_n = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    chk_lat = 1;
    dsend(5, 2, 0, 1, 0, 0, 32'h5, 4, 0);
    dsend(8, 2, 0, 1, 0, 0, 32'h1, 3, 0);
    dsend(20, 2, 1, 1, 0, 0, 32'h0E, 8, 0);
    dsend(5, 2, 0, 1, 1, 1, 32'h0B, 5, 0);
    dsend(0, 0, 0, 0, 1, 1, 32'h1, 1, 0);
    dsend(16'hFFFF, 0, 0, 0, 0, 0, 32'h0000FFFF, 32, 0);
    dsend(16'hFFFF, 0, 0, 0, 1, 1, 32'h0, 0, 1);

    // Back-to-back symbols with no backpressure: one per cycle, fixed latency.
    for (int i = 0; i < 6; i++)
      cycle(1, rval(), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
    idle(4);
    chk("burst_drained", 64'(expq.size()), 64'd0);

    // Random stream with input gaps, random backpressure and occasional clears.
    chk_lat = 0;
    for (int i = 0; i < 80; i++)
      cycle($urandom_range(0, 9) < 7, rval(), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    for (int i = 0; i < 60 && expq.size() > 0; i++) idle(1);
    chk("stream_drained", 64'(expq.size()), 64'd0);

    // Clear in the same cycle as a handshake loads that codeword's length.
    chk_lat = 1;
    dir_en = 1; dir_code = 32'h5; dir_len = 4; dir_ovf = 0;
    cycle(1, 5, 2, 0, 1, 0, 0, 1, 0);
    dir_en = 0;
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("clr_loads_len", 64'(stat_bits), 64'd4);
    idle(1);
    chk("clr_drained", 64'(expq.size()), 64'd0);

    // Reset with three symbols in flight.
    for (int i = 0; i < 3; i++) cycle(1, 5, 2, 0, 1, 0, 0, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_stat_bits", 64'(stat_bits), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    expq.delete();
    mstat = '0;
    prev_stall = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(6);
    dsend(20, 2, 1, 1, 0, 0, 32'h0E, 8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
